// File: rtl/dac_sweep_engine.sv
// Staircase DAC sweep responder: plays a saturating ramp on trigger and pulses done after the last dwell.
// Define DAC_SWEEP_TRIANGLE_EN to retrace the ramp back toward the start (P = 2*num_steps+1).
module dac_sweep_engine #(
  parameter int DAC_W   = 12,
  parameter int NSTEP_W = 10,
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trigger_dac_i,
  input  logic [DAC_W-1:0]   start_code_i,
  input  logic [DAC_W-1:0]   step_code_i,
  input  logic [NSTEP_W-1:0] num_steps_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               dir_i,
  output logic [DAC_W-1:0]   dac_code_o,
  output logic               dac_load_o,
  output logic               busy_o,
  output logic               done_dac_o,
  output logic               clipped_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POINT = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DAC_W-1:0]   code_q, code_d;
  logic [DAC_W-1:0]   step_q, step_d;
  logic [NSTEP_W-1:0] nsteps_q, nsteps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NSTEP_W:0]   idx_q, idx_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               clip_q, clip_d;

  logic [NSTEP_W:0]   total_steps;
  logic               step_dir;
  logic [DAC_W:0]     sum_ext, diff_ext;
  logic [DAC_W-1:0]   next_code;
  logic               next_clip;
  logic [DWELL_W-1:0] dwell_eff;

`ifdef DAC_SWEEP_TRIANGLE_EN
  // Second half of the steps runs opposite to the requested direction.
  assign total_steps = {nsteps_q, 1'b0};
  assign step_dir    = dir_q ^ (idx_q >= {1'b0, nsteps_q});
`else
  assign total_steps = {1'b0, nsteps_q};
  assign step_dir    = dir_q;
`endif

  assign sum_ext   = {1'b0, code_q} + {1'b0, step_q};
  assign diff_ext  = {1'b0, code_q} - {1'b0, step_q};
  assign dwell_eff = (dwell_i == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_i;

  // The extra MSB is the carry (ascending) or borrow (descending).
  always_comb begin
    next_code = '0;
    next_clip = 1'b0;
    if (step_dir) begin
      if (diff_ext[DAC_W]) begin
        next_code = '0;
        next_clip = 1'b1;
      end else begin
        next_code = diff_ext[DAC_W-1:0];
      end
    end else begin
      if (sum_ext[DAC_W]) begin
        next_code = '1;
        next_clip = 1'b1;
      end else begin
        next_code = sum_ext[DAC_W-1:0];
      end
    end
  end

  // The POINT cycle is the first cycle of each point's dwell, so cnt counts the remaining D-1.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    dwell_d  = dwell_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    load_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    clip_d   = clip_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_dac_i) begin
          code_d   = start_code_i;
          step_d   = step_code_i;
          nsteps_d = num_steps_i;
          dwell_d  = dwell_eff;
          dir_d    = dir_i;
          cnt_d    = dwell_eff - 1'b1;
          idx_d    = '0;
          clip_d   = 1'b0;
          load_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_POINT;
        end
      end
      ST_POINT, ST_DWELL: begin
        if (cnt_q == '0) begin
          if (idx_q != total_steps) begin
            code_d  = next_code;
            clip_d  = clip_q | next_clip;
            idx_d   = idx_q + 1'b1;
            cnt_d   = dwell_q - 1'b1;
            load_d  = 1'b1;
            state_d = ST_POINT;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = ST_DWELL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      dwell_q  <= dwell_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clip_q   <= clip_d;
    end
  end

  assign dac_code_o = code_q;
  assign dac_load_o = load_q;
  assign busy_o     = busy_q;
  assign done_dac_o = done_q;
  assign clipped_o  = clip_q;

endmodule

// File: tb/tb_dac_sweep_engine.sv
// Self-checking bench for dac_sweep_engine: directed plan cases plus randomized sweeps vs. a point-list model.
module tb_dac_sweep_engine;

  localparam int DAC_W   = 12;
  localparam int NSTEP_W = 10;
  localparam int DWELL_W = 16;
  localparam int MAXC    = (1 << DAC_W) - 1;
`ifdef DAC_SWEEP_TRIANGLE_EN
  localparam bit TRI = 1'b1;
`else
  localparam bit TRI = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               trigger = 1'b0;
  logic [DAC_W-1:0]   start_code = '0;
  logic [DAC_W-1:0]   step_code = '0;
  logic [NSTEP_W-1:0] num_steps = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               dir = 1'b0;
  logic [DAC_W-1:0]   dac_code;
  logic               dac_load, busy, done_dac, clipped;

  int checks = 0;
  int errors = 0;
  int exp_code[$];
  bit exp_clip[$];

  dac_sweep_engine #(.DAC_W(DAC_W), .NSTEP_W(NSTEP_W), .DWELL_W(DWELL_W)) dut (
    .clk_i(clk), .rst_i(rst), .trigger_dac_i(trigger),
    .start_code_i(start_code), .step_code_i(step_code), .num_steps_i(num_steps),
    .dwell_i(dwell), .dir_i(dir),
    .dac_code_o(dac_code), .dac_load_o(dac_load), .busy_o(busy),
    .done_dac_o(done_dac), .clipped_o(clipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: list of point values plus cumulative clip flag after each point.
  function automatic void build(input int s, input int st, input int n, input bit dr);
    int code, v, total;
    bit clp, d;
    code = s;
    clp  = 1'b0;
    exp_code.delete();
    exp_clip.delete();
    exp_code.push_back(s);
    exp_clip.push_back(1'b0);
    total = TRI ? 2 * n : n;
    for (int i = 0; i < total; i++) begin
      d = dr ^ (TRI && i >= n);
      v = d ? code - st : code + st;
      if (v > MAXC) begin v = MAXC; clp = 1'b1; end
      if (v < 0)    begin v = 0;    clp = 1'b1; end
      code = v;
      exp_code.push_back(v);
      exp_clip.push_back(clp);
    end
  endfunction

  // Entered and left at 1 time unit after a rising edge; leaves in cycle done+1.
  task automatic sweep(input int s, input int st, input int n, input int dw, input bit dr, input bit noise);
    int p, d, k, last;
    build(s, st, n, dr);
    p = exp_code.size();
    d = (dw == 0) ? 1 : dw;
    start_code = DAC_W'(s);
    step_code  = DAC_W'(st);
    num_steps  = NSTEP_W'(n);
    dwell      = DWELL_W'(dw);
    dir        = dr;
    trigger    = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    $display("sweep start=%0d step=%0d steps=%0d dwell=%0d dir=%0d points=%0d noise=%0d",
             s, st, n, dw, dr, p, noise);
    for (int c = 1; c <= p * d + 1; c++) begin
      k = (c <= p * d) ? (c - 1) / d : p - 1;
      chk("load", dac_load, (c <= p * d) && ((c - 1) % d == 0));
      chk("code", dac_code, exp_code[k]);
      chk("busy", busy, c <= p * d);
      chk("done", done_dac, c == p * d + 1);
      chk("clip", clipped, exp_clip[k]);
      if (noise) begin
        trigger    = (c == p * d + 1) ? 1'b1 : 1'($urandom_range(0, 1));
        start_code = DAC_W'($urandom);
        step_code  = DAC_W'($urandom);
        num_steps  = NSTEP_W'($urandom);
        dwell      = DWELL_W'($urandom);
        dir        = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    trigger = 1'b0;
    last = exp_code[p - 1];
    chk("idle_load", dac_load, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done_dac, 0);
    chk("idle_code", dac_code, last);
    chk("idle_clip", clipped, exp_clip[p - 1]);
  endtask

  initial begin
    #2;
    chk("rst_code", dac_code, 0);
    chk("rst_load", dac_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_dac, 0);
    chk("rst_clip", clipped, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    sweep(100, 50, 3, 4, 1'b0, 1'b0);
    sweep(4000, 100, 2, 2, 1'b0, 1'b0);
    sweep(300, 10, 1, 1, 1'b0, 1'b0);
    sweep(777, 5, 0, 0, 1'b1, 1'b0);
    sweep(50, 40, 3, 1, 1'b1, 1'b0);
    sweep(2000, 300, 4, 3, 1'b0, 1'b1);
    sweep(1234, 17, 2, 0, 1'b1, 1'b1);
`ifdef DAC_SWEEP_TRIANGLE_EN
    sweep(1000, 10, 2, 1, 1'b1, 1'b0);
`endif

    // Reset during the dwell of point 1.
    start_code = 12'd500; step_code = 12'd20; num_steps = 10'd3; dwell = 16'd4; dir = 1'b0;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_code", dac_code, 520);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    $display("reset asserted mid-sweep");
    chk("arst_code", dac_code, 0);
    chk("arst_load", dac_load, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done_dac, 0);
    chk("arst_clip", clipped, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      chk("post_rst_done", done_dac, 0);
      chk("post_rst_load", dac_load, 0);
      @(posedge clk); #1;
    end
    sweep(500, 20, 3, 4, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      sweep(int'($urandom_range(0, MAXC)), int'($urandom_range(0, 1500)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_sweep_engine.md
# dac_sweep_engine

Responder side of the task trigger/done handshake for the DAC path. On a one-cycle `trigger_dac` pulse it plays a staircase voltage sweep onto the DAC code bus and returns a one-cycle `done_dac` pulse after the last point's dwell expires. It sits between the task sequencer, which issues `trigger_dac` and waits for `done_dac`, and the DAC interface, which consumes `dac_code`/`dac_load`.

## Interface
- `DAC_W`, default 12: DAC code width.
- `NSTEP_W`, default 10: width of the step-count field.
- `DWELL_W`, default 16: width of the dwell-count field (clk cycles per point).
- `clk`  in  1  system clock.
- `rst`  in  1  system reset; asynchronous, active-high.
- `trigger_dac`  in  1  start pulse; sampled only in IDLE.
- `start_code`  in  DAC_W  first point of the sweep.
- `step_code`  in  DAC_W  unsigned increment per step.
- `num_steps`  in  NSTEP_W  number of increments (points = num_steps+1).
- `dwell`  in  DWELL_W  cycles each point is held; 0 is treated as 1.
- `dir`  in  1  0 = ascending, 1 = descending.
- `dac_code`  out  DAC_W  registered DAC code.
- `dac_load`  out  1  one-cycle strobe, high in the cycle `dac_code` takes a new point.
- `busy`  out  1  high from the first point until the done cycle, exclusive.
- `done_dac`  out  1  one-cycle completion pulse.
- `clipped`  out  1  sticky flag; a step saturated. Cleared on the next accepted trigger.

## Operation
- States:
  - IDLE: on `trigger_dac`, latch `start_code`, `step_code`, `num_steps`, `max(dwell,1)` and `dir`; clear `clipped` and the step counter; go to POINT.
  - POINT: one cycle. `dac_code` = current point and `dac_load` = 1. Load the dwell counter; go to DWELL.
  - DWELL: count down to expiry.
    - If points remain, compute the next code and go to POINT.
    - Otherwise go to DONE.
  - DONE: one cycle with `done_dac` = 1; go to IDLE.
- Next code is current ± `step_code`, computed at DAC_W+1 bits.
  - Overflow above 2^DAC_W−1 clamps to all-ones; underflow below 0 clamps to 0.
  - Either clamp sets `clipped`. The sweep continues at the clamped value.
- Config inputs are ignored after the trigger is latched.
- `trigger_dac` in any non-IDLE state, including DONE, is ignored: no restart, no queueing.
- `dac_code` holds its last value in IDLE.
- Reset values: `dac_code`=0, `dac_load`=0, `busy`=0, `done_dac`=0, `clipped`=0, state IDLE.
- Reset mid-sweep aborts immediately to reset values; no `done_dac` is emitted.

## Timing
- Let T be the cycle in which `trigger_dac` is sampled high in IDLE, and D = max(`dwell`,1).
- Point k (k = 0..P−1) has `dac_load`=1 at cycle T+1+k·D. `dac_code` is stable for D cycles.
- `done_dac`=1 at cycle T+1+P·D. `busy` is high over T+1 .. T+P·D.
- Earliest `done_dac` is T+2 (P=1, D=1). This always lands after the initiator has left its one-cycle trigger state.
- Earliest next accepted trigger is T+2+P·D.

## Configuration
- `DAC_SWEEP_TRIANGLE_EN` defined:
  - After the forward `num_steps` increments, the direction inverts and `num_steps` more steps retrace toward the start.
  - Saturation is applied symmetrically on the return leg.
  - P = 2·`num_steps`+1. The turn-around point is emitted once.
- Not defined: a single-direction sweep with P = `num_steps`+1.
- The port list is identical in both builds.

## Test plan
- Ascending sweep: start=100, step=50, num_steps=3, dwell=4, dir=0, trigger at T.
  - Codes 100/150/200/250 load at T+1/5/9/13.
  - `done_dac` at T+17, `clipped`=0.
- Saturation: start=4000, step=100, num_steps=2, dir=0, DAC_W=12.
  - Codes 4000, 4095, 4095; `clipped`=1.
  - Next trigger clears `clipped`.
- Minimal and zero dwell: num_steps=0, dwell=0.
  - Single point at T+1.
  - `done_dac` at T+2; no extra `dac_load`.
- Retrigger and config change: pulse `trigger_dac` and change `start_code` mid-sweep and in the DONE cycle.
  - The sweep is unaffected and exactly one `done_dac` is produced.
  - A trigger at done+1 is accepted.
- Reset mid-sweep: assert `rst` during the DWELL of point 1.
  - All outputs go to 0 asynchronously; `done_dac` never pulses.
  - A new trigger after reset runs normally.
- `DAC_SWEEP_TRIANGLE_EN` build: start=1000, step=10, num_steps=2, dwell=1, dir=1.
  - Codes 1000/990/980/990/1000 at T+1..T+5.
  - `done_dac` at T+6.
